// File: rtl/ccu_clkreq_pkg.sv
// Shared types and default widths for the CCU clock-request controller.
// Optional ack timeout is enabled by defining CCU_CLKREQ_ACK_TIMEOUT_EN.
package ccu_clkreq_pkg;

    localparam int DEF_NUM_SLICES = 7;
    localparam int DEF_HYST_W     = 8;
    localparam int DEF_TMO_W      = 10;

    typedef enum logic [2:0] {
        OFF,
        REQ,
        ON,
        IDLE,
        DROP
    } ccu_clkreq_state_e;

endpackage

// File: rtl/ccu_clkreq_slice.sv
// One slice: ack synchronizer, four-phase clkreq FSM, idle hysteresis and
// optional ack timeout (CCU_CLKREQ_ACK_TIMEOUT_EN).
module ccu_clkreq_slice
    import ccu_clkreq_pkg::*;
#(
    parameter int HYST_W = DEF_HYST_W,
    parameter int TMO_W  = DEF_TMO_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              busy,
    input  logic [HYST_W-1:0] idle_hyst,
    input  logic [TMO_W-1:0]  ack_tmo,
    input  logic              clkack,
    output logic              clkreq,
    output logic              clk_en,
    output logic              ack_err
);

    ccu_clkreq_state_e state_q, state_d;
    logic [HYST_W-1:0] hyst_q, hyst_d;
    logic ack_m_q, ack_s_q;
    logic clkreq_q, clkreq_d;
    logic clk_en_q, clk_en_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= OFF;
            hyst_q   <= '0;
            ack_m_q  <= 1'b0;
            ack_s_q  <= 1'b0;
            clkreq_q <= 1'b0;
            clk_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hyst_q   <= hyst_d;
            ack_m_q  <= clkack;
            ack_s_q  <= ack_m_q;
            clkreq_q <= clkreq_d;
            clk_en_q <= clk_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hyst_d  = hyst_q;
        unique case (state_q)
            OFF: begin
                if (busy) state_d = REQ;
            end
            REQ: begin
                if (ack_s_q) state_d = ON;
            end
            ON: begin
                if (!busy) begin
                    if (idle_hyst == '0) begin
                        state_d = DROP;
                    end else begin
                        state_d = IDLE;
                        hyst_d  = idle_hyst;
                    end
                end
            end
            IDLE: begin
                // busy wins over a same-cycle expiry
                if (busy) begin
                    state_d = ON;
                end else begin
                    if (hyst_q <= HYST_W'(1)) state_d = DROP;
                    if (hyst_q != '0) hyst_d = hyst_q - HYST_W'(1);
                end
            end
            DROP: begin
                if (!ack_s_q) state_d = OFF;
            end
            default: state_d = OFF;
        endcase
        clkreq_d = state_d inside {REQ, ON, IDLE};
        clk_en_d = state_d inside {ON, IDLE};
    end

    assign clkreq = clkreq_q;
    assign clk_en = clk_en_q;

`ifdef CCU_CLKREQ_ACK_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic err_q, err_d;
    logic enter_wait;

    assign enter_wait = (state_d == REQ  && state_q != REQ) ||
                        (state_d == DROP && state_q != DROP);

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (enter_wait) begin
            tmo_d = ack_tmo;
        end else if ((state_q == REQ || state_q == DROP) &&
                     tmo_q != '0) begin
            tmo_d = tmo_q - TMO_W'(1);
            if (tmo_q == TMO_W'(1)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign ack_err = err_q;
`else
    logic unused_ack_tmo;
    assign unused_ack_tmo = ^ack_tmo;
    assign ack_err = 1'b0;
`endif

endmodule

// File: rtl/ccu_clkreq_ctrl.sv
// Per-slice clkreq/clkack controller array toward the CCU.
// CCU_CLKREQ_ACK_TIMEOUT_EN enables the sticky ack timeout flags.
module ccu_clkreq_ctrl
    import ccu_clkreq_pkg::*;
#(
    parameter int NUM_SLICES = DEF_NUM_SLICES,
    parameter int HYST_W     = DEF_HYST_W,
    parameter int TMO_W      = DEF_TMO_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SLICES-1:0] busy,
    input  logic [HYST_W-1:0]     idle_hyst,
    input  logic [TMO_W-1:0]      ack_tmo,
    input  logic [NUM_SLICES-1:0] clkack,
    output logic [NUM_SLICES-1:0] clkreq,
    output logic [NUM_SLICES-1:0] clk_en,
    output logic [NUM_SLICES-1:0] ack_err
);

    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
        ccu_clkreq_slice #(
            .HYST_W (HYST_W),
            .TMO_W  (TMO_W)
        ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .busy      (busy[i]),
            .idle_hyst (idle_hyst),
            .ack_tmo   (ack_tmo),
            .clkack    (clkack[i]),
            .clkreq    (clkreq[i]),
            .clk_en    (clk_en[i]),
            .ack_err   (ack_err[i])
        );
    end

endmodule

// File: tb/tb_ccu_clkreq_ctrl.sv
// Directed bench for ccu_clkreq_ctrl; inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.
module tb_ccu_clkreq_ctrl;

    localparam int N = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] busy;
    logic [7:0]   idle_hyst;
    logic [9:0]   ack_tmo;
    logic [N-1:0] clkack;
    logic [N-1:0] clkreq;
    logic [N-1:0] clk_en;
    logic [N-1:0] ack_err;

    int errors = 0;
    int checks = 0;

`ifdef CCU_CLKREQ_ACK_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    ccu_clkreq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .busy      (busy),
        .idle_hyst (idle_hyst),
        .ack_tmo   (ack_tmo),
        .clkack    (clkack),
        .clkreq    (clkreq),
        .clk_en    (clk_en),
        .ack_err   (ack_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        busy      = '0;
        clkack    = '0;
        idle_hyst = 8'd5;
        ack_tmo   = 10'd20;
        step(3);
        check("rst_clkreq", 32'(clkreq), 32'h0);
        check("rst_clk_en", 32'(clk_en), 32'h0);
        check("rst_ack_err", 32'(ack_err), 32'h0);
        reset = 1'b0;
        step(7);

        // slice 0: busy at 10, ack at 14
        busy[0] = 1'b1;
        step();
        check("s0_req_11", 32'(clkreq), 32'h01);
        check("s0_en_11", 32'(clk_en), 32'h00);
        step(3);
        clkack[0] = 1'b1;
        step(2);
        check("s0_en_16", 32'(clk_en), 32'h00);
        step();
        check("s0_en_17", 32'(clk_en), 32'h01);
        check("s0_req_17", 32'(clkreq), 32'h01);

        // slice 2: hysteresis 5, then busy back during DROP
        busy[2]   = 1'b1;
        clkack[2] = 1'b1;
        step(3);
        check("s2_on", 32'(clk_en[2]), 32'h1);
        busy[2] = 1'b0;
        step(5);
        check("s2_req_n5", 32'(clkreq[2]), 32'h1);
        check("s2_en_n5", 32'(clk_en[2]), 32'h1);
        step();
        check("s2_req_n6", 32'(clkreq[2]), 32'h0);
        check("s2_en_n6", 32'(clk_en[2]), 32'h0);
        busy[2] = 1'b1;
        step(2);
        check("s2_drop_hold", 32'(clkreq[2]), 32'h0);
        clkack[2] = 1'b0;
        step(3);
        check("s2_req_m3", 32'(clkreq[2]), 32'h0);
        step();
        check("s2_req_m4", 32'(clkreq[2]), 32'h1);
        check("s2_en_m4", 32'(clk_en[2]), 32'h0);

        // slice 3: 3-cycle busy dip does not release
        busy[3]   = 1'b1;
        clkack[3] = 1'b1;
        step(3);
        check("s3_on", 32'(clk_en[3]), 32'h1);
        busy[3] = 1'b0;
        step(3);
        busy[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("s3_dip_req", 32'(clkreq[3]), 32'h1);
        end
        busy[3] = 1'b0;
        step(5);
        check("s3_full_n5", 32'(clkreq[3]), 32'h1);
        step();
        check("s3_full_n6", 32'(clkreq[3]), 32'h0);

        // slice 4: zero hysteresis drops immediately
        idle_hyst = 8'd0;
        busy[4]   = 1'b1;
        clkack[4] = 1'b1;
        step(3);
        check("s4_on", 32'(clk_en[4]), 32'h1);
        busy[4] = 1'b0;
        step();
        check("s4_req_h0", 32'(clkreq[4]), 32'h0);
        check("s4_en_h0", 32'(clk_en[4]), 32'h0);
        idle_hyst = 8'd5;

        // slice 5: ack held low past ack_tmo
        busy[5] = 1'b1;
        step();
        check("s5_req", 32'(clkreq[5]), 32'h1);
        step(19);
        check("s5_err_19", 32'(ack_err[5]), 32'h0);
        step();
        check("s5_err_20", 32'(ack_err[5]), 32'(EXP_ERR));
        clkack[5] = 1'b1;
        step(3);
        check("s5_late_on", 32'(clk_en[5]), 32'h1);
        check("s5_err_sticky", 32'(ack_err[5]), 32'(EXP_ERR));

        // slice 6: reset while IDLE with ack high
        busy   = 7'b1000000;
        clkack = 7'b1000000;
        step(3);
        check("s6_on", 32'(clk_en[6]), 32'h1);
        busy[6] = 1'b0;
        step();
        check("s6_idle", 32'(clk_en[6]), 32'h1);
        reset = 1'b1;
        step();
        check("mid_rst_clkreq", 32'(clkreq), 32'h0);
        check("mid_rst_clk_en", 32'(clk_en), 32'h0);
        check("mid_rst_ack_err", 32'(ack_err), 32'h0);
        reset   = 1'b0;
        busy[6] = 1'b1;
        step();
        check("s6_rel_req", 32'(clkreq), 32'h40);
        check("s6_rel_en1", 32'(clk_en), 32'h00);
        step();
        check("s6_rel_en2", 32'(clk_en), 32'h00);
        step();
        check("s6_rel_en3", 32'(clk_en), 32'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
